outerprodrc_drain: RTL

//  Downstream stage of the outer-product GEMM array. Snapshots the packed ROWNUM x COLNUM

---
 rtl/outerprodrc_drain.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/outerprodrc_drain.sv
// -----------------------------------------------------------------------------
// outerprodrc_drain
//   Drain stage for the outer-product GEMM array. On a capture request it
//   snapshots the packed ROWNUM x COLNUM accumulator matrix into a shadow
//   register. It pulses a clear request back to the array, then streams the
//   snapshot out in row-major order, one element per valid/ready handshake.
//
// Configuration macro:
//   OUTERPRODRC_DRAIN_SAT_EN - when defined, each element is reduced to OW bits
//                              with unsigned saturation. When undefined, it is
//                              reduced by plain truncation.
//
// Ports:
//   iClk      in   clock, rising edge
//   iRst      in   asynchronous reset, active-high
//   iCap      in   capture request (snapshot iMat)
//   iMat      in   packed matrix, element e=r*COLNUM+c at [e*2*OUTBITWIDTH +: 2*OUTBITWIDTH]
//   oClrReq   out  1-cycle pulse after an accepted capture
//   oValid    out  oData/oRow/oCol/oLast are valid
//   iReady    in   consumer accepts the current element
//   oData     out  current element after width reduction
//   oRow      out  row index of oData
//   oCol      out  column index of oData
//   oLast     out  current element is the final one of the matrix
//   oDone     out  1-cycle pulse after the final handshake
//   oCapErr   out  1-cycle pulse after an ignored capture request
//   oDbgState out  FSM state (0 = IDLE, 1 = DRAIN)
//
// Handshake: an element transfers on a rising edge where oValid & iReady.
// oValid is held, with oData/oRow/oCol/oLast stable, until that transfer
// happens. It never drops without a transfer.
// -----------------------------------------------------------------------------
module outerprodrc_drain #(
  parameter int ROWNUM      = 2,
  parameter int COLNUM      = 2,
  parameter int OUTBITWIDTH = 4,
  parameter int OW          = 4,
  localparam int EW = 2 * OUTBITWIDTH,
  localparam int RW = (ROWNUM > 1) ? $clog2(ROWNUM) : 1,
  localparam int CW = (COLNUM > 1) ? $clog2(COLNUM) : 1
) (
  input  logic                          iClk,
  input  logic                          iRst,
  input  logic                          iCap,
  input  logic [ROWNUM*COLNUM*EW-1:0]   iMat,
  output logic                          oClrReq,
  output logic                          oValid,
  input  logic                          iReady,
  output logic [OW-1:0]                 oData,
  output logic [RW-1:0]                 oRow,
  output logic [CW-1:0]                 oCol,
  output logic                          oLast,
  output logic                          oDone,
  output logic                          oCapErr,
  output logic                          oDbgState
);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_DRAIN = 1'b1;

  localparam logic [RW-1:0] LAST_ROW = RW'(ROWNUM - 1);
  localparam logic [CW-1:0] LAST_COL = CW'(COLNUM - 1);

  logic [0:0]                r_state;
  logic [ROWNUM*COLNUM*EW-1:0] r_shadow;
  logic [RW-1:0]             r_row;
  logic [CW-1:0]             r_col;
  logic                      r_clr;
  logic                      r_done;
  logic                      r_caperr;

  logic                      w_valid;
  logic                      w_last;
  logic                      w_hs;
  logic                      w_final;
  int                        w_idx;
  logic [OW-1:0]             w_red;

  assign w_valid = (r_state == S_DRAIN);
  assign w_last  = w_valid && (r_row == LAST_ROW) && (r_col == LAST_COL);
  assign w_hs    = w_valid && iReady;
  assign w_final = w_hs && w_last;

  // Element select and width reduction, straight from the registered snapshot.
  always_comb begin
    w_idx = int'(r_row) * COLNUM + int'(r_col);
`ifdef OUTERPRODRC_DRAIN_SAT_EN
    if (r_shadow[w_idx*EW +: EW] > EW'({OW{1'b1}}))
      w_red = {OW{1'b1}};
    else
      w_red = r_shadow[w_idx*EW +: OW];
`else
    w_red = r_shadow[w_idx*EW +: OW];
`endif
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      r_state  <= S_IDLE;
      r_shadow <= '0;
      r_row    <= '0;
      r_col    <= '0;
      r_clr    <= 1'b0;
      r_done   <= 1'b0;
      r_caperr <= 1'b0;
    end else begin
      r_clr    <= 1'b0;
      r_done   <= 1'b0;
      r_caperr <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (iCap) begin
            r_shadow <= iMat;
            r_row    <= '0;
            r_col    <= '0;
            r_clr    <= 1'b1;
            r_state  <= S_DRAIN;
          end
        end
        default: begin
          if (w_final) begin
            r_done <= 1'b1;
            r_row  <= '0;
            r_col  <= '0;
            // A capture landing on the final transfer chains straight into
            // the next drain, so oValid stays high with no bubble.
            if (iCap) begin
              r_shadow <= iMat;
              r_clr    <= 1'b1;
            end else begin
              r_state  <= S_IDLE;
            end
          end else begin
            if (iCap) r_caperr <= 1'b1;
            if (w_hs) begin
              if (r_col == LAST_COL) begin
                r_col <= '0;
                r_row <= r_row + 1'b1;
              end else begin
                r_col <= r_col + 1'b1;
              end
            end
          end
        end
      endcase
    end
  end

  assign oValid    = w_valid;
  assign oData     = w_valid ? w_red : '0;
  assign oRow      = r_row;
  assign oCol      = r_col;
  assign oLast     = w_last;
  assign oClrReq   = r_clr;
  assign oDone     = r_done;
  assign oCapErr   = r_caperr;
  assign oDbgState = r_state;

endmodule
